// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and 50 MHz timing defaults for the key conditioner
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } key_state_t;

    // Raw key_n level of an idle (released) button.
    localparam logic KEY_RELEASED_RAW = 1'b1;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_REPEAT_DELAY    = 25000000;
    localparam int DEFAULT_REPEAT_PERIOD   = 10000000;

endpackage

// File: rtl/key_pulse_generator_channel.sv
// rtl/key_pulse_generator_channel.sv - one key: synchroniser, debounce FSM, optional repeat
// Auto-repeat is built only when KEY_AUTO_REPEAT_EN is defined.
module key_debounce_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic key_n_i,
    output logic key_level_o,
    output logic press_pulse_o,
    output logic release_pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("key_debounce_channel: timing parameters must be >= 1");
    end

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    key_state_t       state_q, state_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             pressed_s;
    logic             accept;
    logic             rep_fire;

    assign pressed_s = (sync2_q != KEY_RELEASED_RAW);
    // This sample differing from the accepted level completes the stable run.
    assign accept    = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= RELEASED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            RELEASED: begin
                if (pressed_s) begin
                    if (accept) begin
                        state_d = PRESSED;
                    end else begin
                        state_d = PRESS_PEND;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            PRESS_PEND: begin
                if (!pressed_s) begin
                    state_d = RELEASED;
                end else if (accept) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!pressed_s) begin
                    if (accept) begin
                        state_d = RELEASED;
                    end else begin
                        state_d = RELEASE_PEND;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            RELEASE_PEND: begin
                if (pressed_s) begin
                    state_d = PRESSED;
                end else if (accept) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    always_comb begin
        level_d   = (state_d == PRESSED) || (state_d == RELEASE_PEND);
        press_d   = ((state_d == PRESSED) &&
                     ((state_q == RELEASED) || (state_q == PRESS_PEND))) || rep_fire;
        release_d = (state_d == RELEASED) &&
                    ((state_q == RELEASE_PEND) || (state_q == PRESSED));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q   <= KEY_RELEASED_RAW;
            sync2_q   <= KEY_RELEASED_RAW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= key_n_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_q, rep_d, rep_inc, rep_target;
    logic             armed_q, armed_d;

    assign rep_inc    = rep_q + 1'b1;
    // First repeat waits the long delay, later ones the shorter period.
    assign rep_target = armed_q ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY);

    always_comb begin
        rep_d    = rep_q;
        armed_d  = armed_q;
        rep_fire = 1'b0;
        if (state_d == RELEASED) begin
            rep_d   = '0;
            armed_d = 1'b0;
        end else if (state_q == PRESSED && state_d == PRESSED) begin
            if (rep_inc == rep_target) begin
                rep_fire = 1'b1;
                rep_d    = '0;
                armed_d  = 1'b1;
            end else begin
                rep_d = rep_inc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rep_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            rep_q   <= rep_d;
            armed_q <= armed_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign key_level_o     = level_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;

endmodule

// File: rtl/key_pulse_generator.sv
// rtl/key_pulse_generator.sv - debounced press/release pulses for a bank of active-low keys
// Optional auto-repeat: define KEY_AUTO_REPEAT_EN.
module key_pulse_generator
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 3,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk_i           (clk),
            .reset_i         (reset),
            .key_n_i         (key_n[i]),
            .key_level_o     (key_level[i]),
            .press_pulse_o   (press_pulse[i]),
            .release_pulse_o (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_pulse_generator.sv
// tb/tb_key_pulse_generator.sv - directed and random checks of key_pulse_generator against a history model
module tb_key_pulse_generator;

    localparam int NK  = 3;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] key_n = '0;
    logic [NK-1:0] key_level, press_pulse, release_pulse;

    int checks = 0;
    int errors = 0;

    logic [NK-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_prev;
    bit            win [NK][DEB];
    int            nvalid [NK];
    int            held [NK];

    key_pulse_generator #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_n         (key_n),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // A level change is accepted once the last DEB debouncer samples all disagree with it.
    task automatic model_edge(input logic [NK-1:0] kn, input logic rst);
        m_press = '0;
        m_rel   = '0;
        if (rst) begin
            m_s1 = '1; m_s2 = '1; m_level = '0; m_prev = '0;
            for (int k = 0; k < NK; k++) begin
                nvalid[k] = 0;
                held[k]   = 0;
            end
        end else begin
            for (int k = 0; k < NK; k++) begin
                bit p;
                bit all_diff;
                p = (m_s2[k] == 1'b0);
                for (int j = DEB - 1; j > 0; j--) win[k][j] = win[k][j-1];
                win[k][0] = p;
                if (nvalid[k] < DEB) nvalid[k]++;
                all_diff = (nvalid[k] == DEB);
                for (int j = 0; j < DEB; j++) if (win[k][j] == m_level[k]) all_diff = 0;
                if (all_diff) begin
                    m_level[k] = ~m_level[k];
                    if (m_level[k]) begin
                        m_press[k] = 1'b1;
                        held[k]    = 0;
                    end else begin
                        m_rel[k] = 1'b1;
                    end
                end else if (m_level[k] && p && m_prev[k]) begin
                    held[k]++;
`ifdef KEY_AUTO_REPEAT_EN
                    if (held[k] == RD || (held[k] > RD && (held[k] - RD) % RP == 0))
                        m_press[k] = 1'b1;
`endif
                end
                if (!m_level[k]) held[k] = 0;
                m_prev[k] = p;
            end
            m_s2 = m_s1;
            m_s1 = kn;
        end
    endtask

    task automatic tick(input logic [NK-1:0] kn, input logic rst);
        key_n = kn;
        reset = rst;
        @(posedge clk);
        model_edge(kn, rst);
        @(negedge clk);
        chk("key_level", key_level, m_level);
        chk("press_pulse", press_pulse, m_press);
        chk("release_pulse", release_pulse, m_rel);
        chk("exclusive", press_pulse & release_pulse, '0);
    endtask

    task automatic run(input int n, input logic [NK-1:0] kn);
        for (int i = 0; i < n; i++) tick(kn, 1'b0);
    endtask

    int npulse;
    logic [NK-1:0] rk;

    initial begin
        @(negedge clk);

        // Held through reset: counts as a new press after deassertion.
        run(0, '0);
        for (int i = 0; i < 3; i++) tick(3'b000, 1'b1);
        chk("reset_level", key_level, 3'b000);
        chk("reset_press", press_pulse, 3'b000);
        run(5, 3'b000);
        chk("t1_no_early_press", press_pulse, 3'b000);
        tick(3'b000, 1'b0);
        chk("t1_press_edge6", press_pulse, 3'b111);
        tick(3'b000, 1'b0);
        chk("t1_press_one_cycle", press_pulse, 3'b000);
        chk("t1_level", key_level, 3'b111);

        run(5, 3'b111);
        tick(3'b111, 1'b0);
        chk("t1_release_all", release_pulse, 3'b111);
        run(3, 3'b111);

        // Single key press and release.
        run(5, 3'b101);
        tick(3'b101, 1'b0);
        chk("t2_press1", press_pulse, 3'b010);
        run(34, 3'b101);
        chk("t2_level1", key_level, 3'b010);
        run(5, 3'b111);
        chk("t2_no_early_release", release_pulse, 3'b000);
        tick(3'b111, 1'b0);
        chk("t2_release1", release_pulse, 3'b010);
        run(4, 3'b111);

        // Short glitch, then a release bounce while held.
        run(3, 3'b110);
        run(10, 3'b111);
        chk("t3_glitch_level", key_level, 3'b000);
        run(10, 3'b110);
        tick(3'b111, 1'b0);
        run(10, 3'b110);
        chk("t3_bounce_level", key_level, 3'b001);
        run(10, 3'b111);

        // Simultaneous presses.
        run(5, 3'b010);
        tick(3'b010, 1'b0);
        chk("t4_simultaneous", press_pulse, 3'b101);
        run(10, 3'b111);

        // Reset in the middle of a debounce with the key still held.
        run(4, 3'b011);
        tick(3'b011, 1'b1);
        tick(3'b011, 1'b1);
        chk("t5_reset_outputs", key_level | press_pulse | release_pulse, 3'b000);
        run(5, 3'b011);
        chk("t5_no_early", press_pulse, 3'b000);
        tick(3'b011, 1'b0);
        chk("t5_press_after_reset", press_pulse, 3'b100);
        run(10, 3'b111);

        // Long hold: repeat pulses only with auto-repeat.
        npulse = 0;
        for (int i = 0; i < 60; i++) begin
            tick(3'b110, 1'b0);
            if (press_pulse[0]) npulse++;
        end
        checks++;
`ifdef KEY_AUTO_REPEAT_EN
        assert (npulse == 6) else begin
            errors++;
            $error("FAIL t6_hold_pulses observed=%0d expected=%0d", npulse, 6);
        end
`else
        assert (npulse == 1) else begin
            errors++;
            $error("FAIL t6_hold_pulses observed=%0d expected=%0d", npulse, 1);
        end
`endif
        run(10, 3'b111);

        // Random slowly-changing keys with occasional reset.
        rk = 3'b111;
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(0, 5) == 0) rk[k] = ~rk[k];
            tick(rk, ($urandom_range(0, 199) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
